// File: rtl/rtp_pkg.sv
// Shared types and constants for the ray-tracing processor dispatch logic.
package rtp_pkg;

   localparam int HITT_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_FINISH
   } disp_state_e;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr,
// wrapping around.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   always_comb begin
      logic found;
      int   idx;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ray_dispatch_ctrl.sv
// Ray scheduler: round-robin ray issue to traversal units, completion
// arbitration onto the hitT result RAM port, and frame completion tracking.
module ray_dispatch_ctrl
   import rtp_pkg::*;
#(
   parameter int NUM_RAYS  = 1024,
   parameter int NUM_UNITS = 2,
   parameter int ID_W      = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic [NUM_UNITS-1:0]        unit_ready,
   output logic [NUM_UNITS-1:0]        issue_valid,
   output logic [ID_W-1:0]             issue_ray_id,
   input  logic [NUM_UNITS-1:0]        done_valid,
   input  logic [NUM_UNITS*ID_W-1:0]   done_ray_id,
   input  logic [NUM_UNITS*HITT_W-1:0] done_hitT,
   output logic [NUM_UNITS-1:0]        done_ready,
   output logic                        res_we,
   output logic [ID_W-1:0]             res_addr,
   output logic [HITT_W-1:0]           res_hitT,
   output logic                        busy,
   output logic                        rtp_finish,
   output logic [63:0]                 cycle_count,
   output logic                        err_spurious
);

   localparam int PW = ptr_width(NUM_UNITS);
   localparam int CW = ID_W + 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_RAYS - 1);

   disp_state_e state;

   logic [CW-1:0]        next_id;
   logic [CW-1:0]        retired;
   logic [PW-1:0]        issue_ptr;
   logic [PW-1:0]        done_ptr;
   logic [PW-1:0]        issue_nxt;
   logic [PW-1:0]        done_nxt;
   logic [NUM_UNITS-1:0] issue_req;
   logic [NUM_UNITS-1:0] issue_gnt;
   logic [NUM_UNITS-1:0] done_gnt;
   logic [ID_W-1:0]      done_id_sel;
   logic [HITT_W-1:0]    done_hit_sel;
   logic                 issue_hs;
   logic                 done_hs;
   logic                 idle_like;
   logic                 spurious;
   logic                 retire;

   assign issue_req = unit_ready & {NUM_UNITS{state == ST_RUN}};

   rr_arbiter #(.N(NUM_UNITS), .PW(PW)) u_issue_arb (
      .req (issue_req),
      .ptr (issue_ptr),
      .gnt (issue_gnt)
   );

   rr_arbiter #(.N(NUM_UNITS), .PW(PW)) u_done_arb (
      .req (done_valid),
      .ptr (done_ptr),
      .gnt (done_gnt)
   );

   assign issue_valid  = issue_gnt;
   assign issue_ray_id = next_id[ID_W-1:0];
   assign done_ready   = done_gnt;
   assign issue_hs     = |(issue_gnt & unit_ready);
   assign done_hs      = |done_gnt;
   assign idle_like    = (state == ST_IDLE) || (state == ST_FINISH);

   // A ray issued this very cycle counts as outstanding (zero-latency units).
   assign spurious = done_hs &&
                     (idle_like || (retired == next_id && !issue_hs));
   assign retire   = done_hs && !spurious;

   always_comb begin
      issue_nxt    = '0;
      done_nxt     = '0;
      done_id_sel  = '0;
      done_hit_sel = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (issue_gnt[i])
            issue_nxt = (i == NUM_UNITS - 1) ? '0 : PW'(i + 1);
         if (done_gnt[i]) begin
            done_nxt     = (i == NUM_UNITS - 1) ? '0 : PW'(i + 1);
            done_id_sel  = done_ray_id[i*ID_W +: ID_W];
            done_hit_sel = done_hitT[i*HITT_W +: HITT_W];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         next_id      <= '0;
         retired      <= '0;
         issue_ptr    <= '0;
         done_ptr     <= '0;
         cycle_count  <= '0;
         err_spurious <= 1'b0;
         res_we       <= 1'b0;
         res_addr     <= '0;
         res_hitT     <= '0;
         busy         <= 1'b0;
         rtp_finish   <= 1'b0;
      end else begin
         res_we <= retire;
         if (retire) begin
            res_addr <= done_id_sel;
            res_hitT <= done_hit_sel;
         end
         if (done_hs)
            done_ptr <= done_nxt;
         if (spurious)
            err_spurious <= 1'b1;
         unique case (state)
            ST_IDLE, ST_FINISH: begin
               if (start) begin
                  state       <= ST_RUN;
                  busy        <= 1'b1;
                  rtp_finish  <= 1'b0;
                  next_id     <= '0;
                  retired     <= '0;
                  cycle_count <= '0;
                  issue_ptr   <= '0;
                  done_ptr    <= '0;
               end
            end
            ST_RUN, ST_DRAIN: begin
               cycle_count <= cycle_count + 64'd1;
               if (issue_hs) begin
                  next_id   <= next_id + CW'(1);
                  issue_ptr <= issue_nxt;
               end
               if (retire)
                  retired <= retired + CW'(1);
               if (retire && retired == LAST) begin
                  state      <= ST_FINISH;
                  busy       <= 1'b0;
                  rtp_finish <= 1'b1;
               end else if (issue_hs && next_id == LAST) begin
                  state <= ST_DRAIN;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ray_dispatch_ctrl.sv
// Self-checking bench for ray_dispatch_ctrl: behavioural units plus a
// frame-level reference model of issue, retire and result writes.
module tb_ray_dispatch_ctrl;

   localparam int NR = 8;
   localparam int NU = 2;
   localparam int IW = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic [NU-1:0]     unit_ready;
   logic [NU-1:0]     issue_valid;
   logic [IW-1:0]     issue_ray_id;
   logic [NU-1:0]     done_valid;
   logic [NU*IW-1:0]  done_ray_id;
   logic [NU*32-1:0]  done_hitT;
   logic [NU-1:0]     done_ready;
   logic              res_we;
   logic [IW-1:0]     res_addr;
   logic [31:0]       res_hitT;
   logic              busy;
   logic              rtp_finish;
   logic [63:0]       cycle_count;
   logic              err_spurious;

   logic              start1;
   logic [0:0]        unit_ready1;
   logic [0:0]        issue_valid1;
   logic [IW-1:0]     issue_ray_id1;
   logic [0:0]        done_valid1;
   logic [IW-1:0]     done_ray_id1;
   logic [31:0]       done_hitT1;
   logic [0:0]        done_ready1;
   logic              res_we1;
   logic [IW-1:0]     res_addr1;
   logic [31:0]       res_hitT1;
   logic              busy1;
   logic              rtp_finish1;
   logic [63:0]       cycle_count1;
   logic              err_spurious1;

   ray_dispatch_ctrl #(.NUM_RAYS(NR), .NUM_UNITS(NU), .ID_W(IW)) u_dut (
      .clock(clock), .reset(reset), .start(start),
      .unit_ready(unit_ready), .issue_valid(issue_valid),
      .issue_ray_id(issue_ray_id), .done_valid(done_valid),
      .done_ray_id(done_ray_id), .done_hitT(done_hitT),
      .done_ready(done_ready), .res_we(res_we), .res_addr(res_addr),
      .res_hitT(res_hitT), .busy(busy), .rtp_finish(rtp_finish),
      .cycle_count(cycle_count), .err_spurious(err_spurious)
   );

   ray_dispatch_ctrl #(.NUM_RAYS(1), .NUM_UNITS(1), .ID_W(IW)) u_one (
      .clock(clock), .reset(reset), .start(start1),
      .unit_ready(unit_ready1), .issue_valid(issue_valid1),
      .issue_ray_id(issue_ray_id1), .done_valid(done_valid1),
      .done_ray_id(done_ray_id1), .done_hitT(done_hitT1),
      .done_ready(done_ready1), .res_we(res_we1), .res_addr(res_addr1),
      .res_hitT(res_hitT1), .busy(busy1), .rtp_finish(rtp_finish1),
      .cycle_count(cycle_count1), .err_spurious(err_spurious1)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      int u;
      int id;
      int due;
   } ent_t;

   ent_t        outq[$];
   logic [31:0] hitv[NR];
   int          cyc = 0;
   int          env_issued = 0;
   int          ready_mode = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          hold = 1'b0;
   bit          inj[NU];
   logic [IW-1:0] inj_id = '0;

   bit          m_active, m_finish, m_err, m_we;
   int          m_next, m_ret, m_iptr, m_dptr;
   longint      m_cyc;
   logic [IW-1:0] m_addr;
   logic [31:0] m_hit;

   int          n_we, n_iss1, n_both;
   logic [NR-1:0] wmask;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_finish = 0; m_err = 0; m_we = 0;
      m_next = 0; m_ret = 0; m_iptr = 0; m_dptr = 0; m_cyc = 0;
      m_addr = '0; m_hit = '0;
   endtask

   task automatic drive_inputs();
      bit seen;
      for (int u = 0; u < NU; u++) begin
         if (ready_mode == 0) unit_ready[u] = 1'b1;
         else if (ready_mode == 1) unit_ready[u] = (u == 0);
         else unit_ready[u] = 1'($urandom_range(0, 1));
         done_valid[u] = 1'b0;
         done_ray_id[u*IW +: IW] = '0;
         done_hitT[u*32 +: 32] = '0;
         if (inj[u]) begin
            done_valid[u] = 1'b1;
            done_ray_id[u*IW +: IW] = inj_id;
            done_hitT[u*32 +: 32] = 32'hDEAD_BEEF;
         end else begin
            seen = 0;
            foreach (outq[k]) begin
               if (!seen && outq[k].u == u) begin
                  seen = 1;
                  if (outq[k].due <= cyc && !(hold && env_issued < NR)) begin
                     done_valid[u] = 1'b1;
                     done_ray_id[u*IW +: IW] = IW'(outq[k].id);
                     done_hitT[u*32 +: 32] = hitv[outq[k].id];
                  end
               end
            end
         end
      end
   endtask

   task automatic step();
      int eg_i, eg_d, u, ai, ad, kdel;
      logic [IW-1:0] sid, e_addr;
      logic [31:0] e_hit;
      logic [NU-1:0] eiv, edr;
      bit spur;
      @(negedge clock);
      eg_i = -1;
      eg_d = -1;
      for (int k = 0; k < NU; k++) begin
         u = (m_iptr + k) % NU;
         if (eg_i < 0 && m_active && m_next < NR && unit_ready[u]) eg_i = u;
         u = (m_dptr + k) % NU;
         if (eg_d < 0 && done_valid[u]) eg_d = u;
      end
      eiv = '0;
      edr = '0;
      e_addr = '0;
      e_hit = '0;
      if (eg_i >= 0) eiv[eg_i] = 1'b1;
      if (eg_d >= 0) begin
         edr[eg_d] = 1'b1;
         e_addr = done_ray_id[eg_d*IW +: IW];
         e_hit = done_hitT[eg_d*32 +: 32];
      end
      chk("issue_valid", 64'(issue_valid), 64'(eiv));
      if (eg_i >= 0) chk("issue_ray_id", 64'(issue_ray_id), 64'(m_next));
      chk("done_ready", 64'(done_ready), 64'(edr));
      chk("busy", 64'(busy), 64'(m_active));
      chk("rtp_finish", 64'(rtp_finish), 64'(m_finish));
      chk("res_we", 64'(res_we), 64'(m_we));
      if (m_we) begin
         chk("res_addr", 64'(res_addr), 64'(m_addr));
         chk("res_hitT", 64'(res_hitT), 64'(m_hit));
      end
      chk("cycle_count", cycle_count, 64'(m_cyc));
      chk("err_spurious", 64'(err_spurious), 64'(m_err));
      if (res_we === 1'b1) begin
         n_we++;
         if (res_addr < NR) wmask[res_addr] = 1'b1;
      end
      if (issue_valid[1] === 1'b1) n_iss1++;
      if (done_valid == 2'b11) n_both++;
      ai = -1;
      ad = -1;
      for (int k = 0; k < NU; k++) begin
         if (issue_valid[k] === 1'b1 && unit_ready[k]) ai = k;
         if (done_ready[k] === 1'b1 && done_valid[k]) ad = k;
      end
      sid = issue_ray_id;
      @(posedge clock);
      if (reset) begin
         model_reset();
         outq.delete();
         for (int k = 0; k < NU; k++) inj[k] = 0;
         env_issued = 0;
      end else begin
         spur = (eg_d >= 0) && (!m_active || (m_ret == m_next && eg_i < 0));
         m_we = (eg_d >= 0) && !spur;
         if (m_we) begin
            m_addr = e_addr;
            m_hit = e_hit;
         end
         if (eg_d >= 0) begin
            m_dptr = (eg_d + 1) % NU;
            if (spur) m_err = 1;
         end
         if (m_active) begin
            m_cyc++;
            if (eg_i >= 0) begin
               m_next++;
               m_iptr = (eg_i + 1) % NU;
            end
            if (m_we) m_ret++;
            if (m_ret == NR) begin
               m_active = 0;
               m_finish = 1;
            end
         end else if (start) begin
            m_active = 1; m_finish = 0; m_next = 0; m_ret = 0;
            m_cyc = 0; m_iptr = 0; m_dptr = 0;
         end
         if (ai >= 0) begin
            outq.push_back('{ai, int'(sid),
                             cyc + int'($urandom_range(lat_min, lat_max))});
            env_issued++;
         end
         if (ad >= 0) begin
            if (inj[ad]) inj[ad] = 0;
            else begin
               kdel = -1;
               foreach (outq[k]) if (kdel < 0 && outq[k].u == ad) kdel = k;
               if (kdel >= 0) outq.delete(kdel);
            end
         end
      end
      cyc++;
      #1;
      start = 1'b0;
      reset = 1'b0;
      drive_inputs();
   endtask

   task automatic run_frame(input int mode, input int lmin, input int lmax,
                            input bit hld);
      int budget;
      ready_mode = mode;
      lat_min = lmin;
      lat_max = lmax;
      hold = hld;
      env_issued = 0;
      for (int i = 0; i < NR; i++) hitv[i] = $urandom;
      n_we = 0; n_iss1 = 0; n_both = 0; wmask = '0;
      drive_inputs();
      start = 1'b1;
      step();
      budget = 0;
      while (!m_finish && budget < 300) begin
         step();
         budget++;
      end
      step();
      chk("frame_finish", 64'(rtp_finish), 64'd1);
      chk("we_count", 64'(n_we), 64'(NR));
      chk("addr_set", 64'(wmask), 64'({NR{1'b1}}));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      reset = 1'b1;
      start = 1'b0;
      unit_ready = '0;
      done_valid = '0;
      done_ray_id = '0;
      done_hitT = '0;
      start1 = 1'b0;
      unit_ready1 = '0;
      done_valid1 = '0;
      done_ray_id1 = '0;
      done_hitT1 = '0;
      for (int k = 0; k < NU; k++) inj[k] = 0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_res_addr", 64'(res_addr), 64'd0);
      chk("rst_res_hitT", 64'(res_hitT), 64'd0);
      chk("rst_one_busy", 64'(busy1), 64'd0);
      chk("rst_one_finish", 64'(rtp_finish1), 64'd0);
      step();

      // two always-ready units, three-cycle completion latency
      run_frame(0, 3, 3, 0);
      chk("cycle_count_A", cycle_count, 64'd11);

      // unit 1 never ready: everything goes to unit 0
      run_frame(1, 1, 4, 0);
      chk("unit1_no_issue", 64'(n_iss1), 64'd0);

      // completions held until all issued: both units valid together
      run_frame(0, 1, 2, 1);
      chk("both_valid_ge4", 64'(n_both >= 4), 64'd1);

      for (int f = 0; f < 3; f++) run_frame(2, 1, 6, 0);

      // reset in the middle of a frame
      ready_mode = 0; lat_min = 2; lat_max = 4; hold = 0;
      env_issued = 0;
      drive_inputs();
      start = 1'b1;
      step();
      b = 0;
      while (env_issued < 3 && b < 50) begin
         step();
         b++;
      end
      chk("three_issued", 64'(env_issued), 64'd3);
      reset = 1'b1;
      unit_ready = '0;
      done_valid = '0;
      step();
      step();
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_issue", 64'(issue_valid), 64'd0);
      chk("mid_rst_cc", cycle_count, 64'd0);
      run_frame(2, 1, 3, 0);

      // completion while idle is flagged and dropped
      reset = 1'b1;
      step();
      inj[0] = 1;
      inj_id = 16'd5;
      drive_inputs();
      step();
      step();
      chk("spur_err", 64'(err_spurious), 64'd1);
      chk("spur_we", 64'(res_we), 64'd0);
      run_frame(2, 1, 4, 0);

      // single ray, zero-latency unit
      @(posedge clock);
      #1;
      start1 = 1'b1;
      @(posedge clock);
      #1;
      start1 = 1'b0;
      unit_ready1 = 1'b1;
      done_valid1 = 1'b1;
      done_ray_id1 = '0;
      done_hitT1 = 32'h3F80_0000;
      @(negedge clock);
      chk("one_issue", 64'(issue_valid1), 64'd1);
      chk("one_issue_id", 64'(issue_ray_id1), 64'd0);
      chk("one_done_ready", 64'(done_ready1), 64'd1);
      chk("one_busy", 64'(busy1), 64'd1);
      @(posedge clock);
      #1;
      unit_ready1 = 1'b0;
      done_valid1 = 1'b0;
      @(negedge clock);
      chk("one_finish", 64'(rtp_finish1), 64'd1);
      chk("one_busy_off", 64'(busy1), 64'd0);
      chk("one_we", 64'(res_we1), 64'd1);
      chk("one_addr", 64'(res_addr1), 64'd0);
      chk("one_hitT", 64'(res_hitT1), 64'h3F80_0000);
      chk("one_cc", cycle_count1, 64'd1);
      chk("one_err", 64'(err_spurious1), 64'd0);
      @(negedge clock);
      chk("one_we_pulse", 64'(res_we1), 64'd0);
      chk("one_finish_hold", 64'(rtp_finish1), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
